fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Prefetch buffer between the PC register and the decode stage.
- Takes the current PC from the fetch stage and issues in-order requests to instruction memory.
- Pairs each returned instruction word with its PC, buffers up to DEPTH entries and presents them to decode over a valid/ready handshake.
- Drives the PC register enable, so the PC advances only when a request is accepted. A redirect (jump/branch) flushes the queue and all in-flight responses.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy, outstanding and drop counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- fetch_pc  in  32  current PC from the PC register.
- fetch_en  out  1  PC register enable; equals imem_req & imem_gnt.
- flush  in  1  redirect (jump_target | jump_branch taken); discards everything queued and in flight.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; equals fetch_pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- id_valid  out  1  head entry holds a complete instruction.
- id_ready  in  1  decode accepts the head entry.
- id_instr  out  32  head instruction word.
- id_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (rst=0, async): all entries invalid, rd/wr pointers 0, occupancy, outstanding and drop_cnt all 0. Outputs: id_valid=0, imem_req=0, fetch_en=0, id_instr=0, id_pc=0.
- Entry allocation at issue: a granted request (imem_req & imem_gnt) allocates the tail entry with pc=fetch_pc and filled=0. The data fill pointer advances on each non-dropped imem_rvalid, writes imem_rdata and sets filled=1.
- Capacity: imem_req = !flush & (alloc_count + drop_cnt < DEPTH), where alloc_count is the number of allocated entries, filled or not. imem_req never depends on imem_gnt.
- Output: id_valid = head allocated & filled. id_instr and id_pc come from the head entry register.
- Pop on id_valid & id_ready. Push, fill and pop may all occur in one cycle; counters update by net change.
- Latency: grant in cycle t, rvalid in cycle t+k, id_valid in cycle t+k+1 (registered path).
- Flush, in the cycle it is asserted:
  - All entries invalidated, pointers reset, id_valid=0 next cycle.
  - drop_cnt loads (outstanding − (rvalid this cycle ? 1 : 0)). The rvalid in the flush cycle is discarded.
  - imem_req=0, so no grant and fetch_en=0; the PC register loads the redirect target via its own path.
- Drop: while drop_cnt>0, each imem_rvalid decrements drop_cnt and its data is discarded. New requests may issue during draining; their responses arrive after the dropped ones because responses are in order.
- Flush coinciding with a pop: flush wins. The decode stage squashes the popped instruction itself.
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is alloc_count==DEPTH; empty is alloc_count==0.
- imem_rvalid with no outstanding request and drop_cnt==0 is illegal. Covered by an assertion in simulation only.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue has no filled head and the incoming imem_rvalid targets the head entry (not dropped, no flush), the block asserts id_valid in the same cycle. id_instr = imem_rdata combinationally and id_pc = head pc. If id_ready, the entry is consumed without being written.
- Defined, timing: response-to-decode latency becomes 0 cycles.
- Not defined: fully registered path, latency 1 cycle as above.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each grant, id_ready=1, PC sequence 0x0,0x4,0x8 → one request per cycle. id_pc/id_instr appear in order with latency 1 (0 with bypass); fetch_en high every granted cycle.
- id_ready=0 with DEPTH=4 → exactly 4 grants, then imem_req=0 and fetch_en=0 until the first pop. Pop one entry → imem_req reasserts the next cycle.
- Two requests outstanding (pc 0x10, 0x14), assert flush; the next two rvalids carry 0xDEAD → neither reaches decode. A new request to 0x40 returns 0x1234 → id_pc=0x40, id_instr=0x1234.
- Flush in the same cycle as an rvalid for pc 0x20 and a pop of the head → that data is dropped, drop_cnt = outstanding−1, id_valid=0 next cycle.
- Wrap: 10 back-to-back instructions with random id_ready and gnt stalls → output order and PCs match the issued sequence exactly, with no loss or duplication.
- rst pulled low mid-stream with 3 entries held → id_valid and imem_req drop immediately (async). After release, fetching restarts from the current fetch_pc with an empty queue.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between the PC register and decode
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (same-cycle response-to-decode bypass)
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        fetch_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] fill_ptr;

  // outstanding counts every granted request whose response has not yet
  // returned, including the ones that will be dropped after a flush; that is
  // what makes the flush-time drop_cnt load a simple subtraction.
  logic [CNT_W-1:0] alloc_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;

  logic head_alloc;
  logic resp_keep;
  logic grant;
  logic pop;
  logic fill_we;
  logic byp_hit;

  // Request gating, response qualification and the decode-facing head view
  always_comb begin
    head_alloc = (alloc_cnt != '0);
    resp_keep  = imem_rvalid & (drop_cnt == '0) & ~flush;
    // Dropped responses still need a slot accounted for, so they count
    // against capacity until they have drained.
    imem_req   = rst & ~flush & (({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < CAP);
    imem_addr  = fetch_pc;
    grant      = imem_req & imem_gnt;
    fetch_en   = grant;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_hit    = resp_keep & head_alloc & ~filled[rd_ptr] & (fill_ptr == rd_ptr);
`else
    byp_hit    = 1'b0;
`endif
    id_valid   = (head_alloc & filled[rd_ptr]) | byp_hit;
    id_instr   = byp_hit ? imem_rdata : instr_mem[rd_ptr];
    id_pc      = pc_mem[rd_ptr];
    pop        = id_valid & id_ready;
    // A bypassed word consumed by decode never lands in the entry.
    fill_we    = resp_keep & ~(byp_hit & id_ready);
  end

  // Pointers and counters; flush wins over any push, fill or pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      outstanding <= outstanding - CNT_W'(imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(imem_rvalid);
    end else begin
      wr_ptr      <= wr_ptr + PTR_W'(grant);
      fill_ptr    <= fill_ptr + PTR_W'(resp_keep);
      rd_ptr      <= rd_ptr + PTR_W'(pop);
      alloc_cnt   <= alloc_cnt + CNT_W'(grant) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
      if (imem_rvalid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  // Entry storage: PC captured at grant, instruction word captured at fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      filled <= '0;
    end else begin
      if (grant) begin
        pc_mem[wr_ptr] <= fetch_pc;
        filled[wr_ptr] <= 1'b0;
      end
      if (fill_we) begin
        instr_mem[fill_ptr] <= imem_rdata;
        filled[fill_ptr]    <= 1'b1;
      end
      if (pop) begin
        filled[rd_ptr] <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // A response is only legal while some granted request is still in flight
  always @(posedge clk) begin
    if (rst) begin
      assert (!(imem_rvalid && (outstanding == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (honours FETCH_QUEUE_BYPASS_EN)
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  typedef struct {
    logic [31:0] pc;
    int          gcyc;
    bit          filled;
  } sb_t;

  typedef struct {
    logic [31:0] data;
    int          gcyc;
  } mq_t;

  sb_t sb[$];
  mq_t mq[$];

  int          drop_m;
  int          cyc;
  int          tests;
  int          fails;
  int          n_grant;
  int          n_pop;
  int          issue_left;
  int          gnt_pct;
  int          rdy_pct;
  int          rsp_pct;
  int          base;
  bit          check_lat;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic [31:0] flush_target;
  logic [31:0] rel_pc;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    if (pc == 32'h40) return 32'h1234;
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit fl);
    bit exp_req;
    bit keep;
    bit exp_valid;
    bit grant;
    bit do_pop;
    bit byp;
    bit done;
    flush     = fl;
    imem_gnt  = (issue_left > 0) && ($urandom_range(99) < gnt_pct);
    id_ready  = ($urandom_range(99) < rdy_pct);
    if (mq.size() > 0 && mq[0].gcyc < cyc && $urandom_range(99) < rsp_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req   = rst && !fl && (sb.size() + drop_m < DEPTH);
    keep      = imem_rvalid && (drop_m == 0) && !fl;
    exp_valid = (sb.size() > 0) && (sb[0].filled || (BYP && keep));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("fetch_en", 32'(fetch_en), 32'(exp_req && imem_gnt));
    chk("imem_addr", imem_addr, fetch_pc);
    chk("id_valid", 32'(id_valid), 32'(exp_valid));
    do_pop = exp_valid && id_ready;
    if (do_pop) begin
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_instr", id_instr, data_of(sb[0].pc));
      if (check_lat) chk("latency", 32'(cyc - sb[0].gcyc), 32'(LAT));
      last_pc    = id_pc;
      last_instr = id_instr;
    end
    grant = exp_req && imem_gnt;
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      void'(mq.pop_front());
      if (drop_m > 0) drop_m--;
    end
    byp = 1'b0;
    if (do_pop) begin
      byp = !sb[0].filled;
      void'(sb.pop_front());
      n_pop++;
    end
    if (keep && !byp) begin
      done = 1'b0;
      for (int i = 0; i < sb.size(); i++) begin
        if (!done && !sb[i].filled) begin
          sb[i].filled = 1'b1;
          done = 1'b1;
        end
      end
    end
    if (fl) begin
      sb.delete();
      drop_m = mq.size();
      for (int i = 0; i < mq.size(); i++) mq[i].data = 32'hDEAD;
      fetch_pc = flush_target;
    end
    if (grant) begin
      mq.push_back('{data_of(fetch_pc), cyc});
      sb.push_back('{fetch_pc, cyc, 1'b0});
      fetch_pc = fetch_pc + 32'd4;
      n_grant++;
      issue_left--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || mq.size() != 0 || issue_left > 0) && n < bound) begin
      step(1'b0);
      n++;
    end
    chk("drain", 32'(sb.size() + mq.size() + issue_left), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; drop_m = 0; n_grant = 0; n_pop = 0;
    issue_left = 0; gnt_pct = 100; rdy_pct = 100; rsp_pct = 100; check_lat = 1'b0;
    last_pc = '0; last_instr = '0; flush_target = '0;
    rst = 1'b1; fetch_pc = 32'h0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    rst = 1'b1;

    // streaming: one request per cycle, latency checked on every pop
    check_lat = 1'b1;
    base = n_pop;
    issue_left = 3;
    drain(40);
    check_lat = 1'b0;
    chk("stream_pops", 32'(n_pop - base), 32'd3);

    // backpressure: exactly DEPTH grants, then one pop frees one slot
    base = n_grant;
    rdy_pct = 0;
    issue_left = 8;
    repeat (8) step(1'b0);
    chk("grants_full", 32'(n_grant - base), 32'd4);
    chk("req_full", 32'(imem_req), 32'd0);
    rdy_pct = 100;
    step(1'b0);
    rdy_pct = 0;
    step(1'b0);
    chk("grants_after_pop", 32'(n_grant - base), 32'd5);
    rdy_pct = 100;
    issue_left = 0;
    drain(60);

    // flush with two requests in flight; their poisoned data must vanish
    fetch_pc = 32'h10;
    issue_left = 2;
    rsp_pct = 0;
    step(1'b0);
    step(1'b0);
    flush_target = 32'h40;
    step(1'b1);
    chk("drop_cnt_two", 32'(dut.drop_cnt), 32'd2);
    base = n_pop;
    issue_left = 1;
    rsp_pct = 100;
    drain(40);
    chk("flush_pops", 32'(n_pop - base), 32'd1);
    chk("flush_new_pc", last_pc, 32'h40);
    chk("flush_new_instr", last_instr, 32'h1234);

    // flush coinciding with an rvalid (pc 0x20) and a pop of the head
    fetch_pc = 32'h1C;
    issue_left = 3;
    rsp_pct = 0;
    rdy_pct = 0;
    repeat (3) step(1'b0);
    issue_left = 0;
    rsp_pct = 100;
    step(1'b0);
    rdy_pct = 100;
    flush_target = 32'h200;
    step(1'b1);
    chk("drop_cnt_minus_one", 32'(dut.drop_cnt), 32'd1);
    chk("flush_valid_low", 32'(id_valid), 32'd0);
    drain(40);

    // wrap-around with random stalls on grant, response and decode
    base = n_pop;
    issue_left = 10;
    gnt_pct = 70;
    rdy_pct = 50;
    rsp_pct = 60;
    drain(400);
    chk("wrap_pops", 32'(n_pop - base), 32'd10);

    // asynchronous reset mid-stream with three entries held
    gnt_pct = 100;
    rsp_pct = 100;
    rdy_pct = 0;
    issue_left = 3;
    repeat (5) step(1'b0);
    chk("held_valid", 32'(id_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_id_valid", 32'(id_valid), 32'd0);
    chk("async_imem_req", 32'(imem_req), 32'd0);
    sb.delete();
    mq.delete();
    drop_m = 0;
    issue_left = 0;
    @(negedge clk);
    repeat (2) step(1'b0);
    rst = 1'b1;
    rel_pc = fetch_pc;
    rdy_pct = 100;
    issue_left = 2;
    drain(40);
    chk("restart_pc", last_pc, rel_pc + 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
